// File: rtl/jk_mod_counter_if.sv
// ---------------------------------------------------------------------------
// jk_mod_counter_if
//   Control/status bundle for jk_mod_counter: mode/JK/load controls in,
//   count and flags out.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             err;

  modport master (
    output en, mode, j, k, load, load_val,
    input  q, tc, wrap, err
  );

  modport slave (
    input  en, mode, j, k, load, load_val,
    output q, tc, wrap, err
  );
endinterface

`default_nettype wire

// File: rtl/jk_mod_counter.sv
// ---------------------------------------------------------------------------
// jk_mod_counter
//   WIDTH-bit modulo counter with hold/up/down/bitwise-JK modes, synchronous
//   load, terminal count, wrap pulse and sticky range-error flag.
//   Optional macro JK_CNT_SYNC_CLR_EN adds a highest-priority synchronous clr.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jk_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int RESET_VAL = 0
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
`ifdef JK_CNT_SYNC_CLR_EN
  input  wire logic          clr,
`endif
  jk_mod_counter_if.slave    bus
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_JK   = 2'b11;

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH) || RESET_VAL < 0 || RESET_VAL >= MODULUS)
  begin : g_param_check
    $error("jk_mod_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic             tc_w;
  logic [WIDTH-1:0] jk_raw_w;
  logic             load_ok_w;
  logic             jk_ok_w;

  assign tc_w = ((bus.mode == MODE_UP)   && (q_q == MAX_Q)) ||
                ((bus.mode == MODE_DOWN) && (q_q == '0));

  // Characteristic JK equation per bit: set on J, keep unless K.
  assign jk_raw_w  = (bus.j & ~q_q) | (~bus.k & q_q);

  assign load_ok_w = {1'b0, bus.load_val} < MOD_W;
  assign jk_ok_w   = {1'b0, jk_raw_w} < MOD_W;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = err_q;
`ifdef JK_CNT_SYNC_CLR_EN
    if (clr) begin
      q_d   = RST_Q;
      err_d = 1'b0;
    end else
`endif
    if (bus.load) begin
      if (load_ok_w) begin
        q_d = bus.load_val;
      end else begin
        q_d   = MAX_Q;
        err_d = 1'b1;
      end
    end else if (bus.en) begin
      case (bus.mode)
        MODE_UP: begin
          q_d    = (q_q == MAX_Q) ? '0 : q_q + WIDTH'(1);
          wrap_d = tc_w;
        end
        MODE_DOWN: begin
          q_d    = (q_q == '0) ? MAX_Q : q_q - WIDTH'(1);
          wrap_d = tc_w;
        end
        MODE_JK: begin
          if (jk_ok_w) begin
            q_d = jk_raw_w;
          end else begin
            q_d   = MAX_Q;
            err_d = 1'b1;
          end
        end
        MODE_HOLD: q_d = q_q;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.tc   = tc_w;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_mod_counter
//   Directed and random checks of jk_mod_counter against an integer model.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jk_mod_counter;
  localparam int W  = 4;
  localparam int M  = 10;
  localparam int RV = 0;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic clr_v   = 1'b0;
`ifdef JK_CNT_SYNC_CLR_EN
  logic clr;
  assign clr = clr_v;
`endif

  jk_mod_counter_if #(.WIDTH(W)) bus ();

  jk_mod_counter #(
    .WIDTH    (W),
    .MODULUS  (M),
    .RESET_VAL(RV)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
`ifdef JK_CNT_SYNC_CLR_EN
    .clr    (clr),
`endif
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mq;
  int mw;
  int me;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_tc();
    if (bus.mode == 2'b01 && mq == M - 1) return 1;
    if (bus.mode == 2'b10 && mq == 0) return 1;
    return 0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".q"},    32'(bus.q),    32'(mq));
    check({tag, ".wrap"}, 32'(bus.wrap), 32'(mw));
    check({tag, ".err"},  32'(bus.err),  32'(me));
    check({tag, ".tc"},   32'(bus.tc),   32'(model_tc()));
  endtask

  task automatic apply(input bit en, input bit [1:0] mode, input bit [3:0] j,
                       input bit [3:0] k, input bit load, input bit [3:0] lv);
    bus.en       = en;
    bus.mode     = mode;
    bus.j        = j;
    bus.k        = k;
    bus.load     = load;
    bus.load_val = lv;
  endtask

  // Next state from the written rules, using plain integer arithmetic.
  task automatic tick(input string tag);
    int nq, nw, ne, raw, jb, kb, qb;
    nq = mq; nw = 0; ne = me;
`ifdef JK_CNT_SYNC_CLR_EN
    if (clr_v) begin
      nq = RV; ne = 0;
    end else
`endif
    if (bus.load) begin
      if (int'(bus.load_val) < M) nq = int'(bus.load_val);
      else begin nq = M - 1; ne = 1; end
    end else if (bus.en) begin
      case (bus.mode)
        2'b01: begin nw = (mq == M - 1); nq = (mq + 1) % M; end
        2'b10: begin nw = (mq == 0); nq = (mq + M - 1) % M; end
        2'b11: begin
          raw = 0;
          for (int i = 0; i < W; i++) begin
            jb = int'(bus.j[i]); kb = int'(bus.k[i]); qb = (mq >> i) & 1;
            if (jb == 1 && kb == 1) qb = 1 - qb;
            else if (jb == 1) qb = 1;
            else if (kb == 1) qb = 0;
            raw += qb << i;
          end
          if (raw >= M) begin nq = M - 1; ne = 1; end
          else nq = raw;
        end
        default: nq = mq;
      endcase
    end
    @(posedge clk);
    #1;
    mq = nq; mw = nw; me = ne;
    check_all(tag);
  endtask

  initial begin
    mq = RV; mw = 0; me = 0;
    apply(0, 2'b00, 4'h0, 4'h0, 0, 4'h0);
    #12;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick("hold_after_reset");

    // Async reset mid-count at q=7.
    apply(0, 2'b01, 4'h0, 4'h0, 1, 4'd7);
    tick("load7");
    apply(1, 2'b01, 4'h0, 4'h0, 0, 4'h0);
    #3;
    reset_n = 1'b0;
    #1;
    mq = RV; mw = 0; me = 0;
    check_all("async_reset");
    @(negedge clk);
    reset_n = 1'b1;

    apply(0, 2'b01, 4'h0, 4'h0, 1, 4'd8);
    tick("load8");
    apply(1, 2'b01, 4'h0, 4'h0, 0, 4'h0);
    tick("up_to9");
    tick("up_wrap");
    tick("up_after_wrap");

    apply(0, 2'b10, 4'h0, 4'h0, 1, 4'd1);
    tick("load1");
    apply(1, 2'b10, 4'h0, 4'h0, 0, 4'h0);
    tick("down_to0");
    tick("down_wrap");
    apply(0, 2'b10, 4'h0, 4'h0, 1, 4'd0);
    tick("load0");
    apply(0, 2'b10, 4'h0, 4'h0, 0, 4'h0);
    tick("down_en0_a");
    tick("down_en0_b");

    apply(0, 2'b00, 4'h0, 4'h0, 1, 4'b0101);
    tick("load5");
    apply(1, 2'b11, 4'b1010, 4'b0110, 0, 4'h0);
    tick("jk_mix");
    apply(1, 2'b11, 4'b0110, 4'b0000, 0, 4'h0);
    tick("jk_clamp");
    apply(1, 2'b00, 4'h0, 4'h0, 0, 4'h0);
    tick("err_sticky");

    apply(1, 2'b01, 4'h0, 4'h0, 1, 4'd3);
    tick("load_over_up");
    apply(1, 2'b01, 4'h0, 4'h0, 1, 4'd12);
    tick("load_clamp");

`ifdef JK_CNT_SYNC_CLR_EN
    apply(0, 2'b00, 4'h0, 4'h0, 1, 4'd6);
    tick("load6");
    clr_v = 1'b1;
    apply(1, 2'b01, 4'h0, 4'h0, 1, 4'd4);
    tick("clr_with_load");
    clr_v = 1'b0;
`endif

    for (int n = 0; n < 400; n++) begin
      apply($urandom_range(0, 3) != 0, 2'($urandom), 4'($urandom), 4'($urandom),
            $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
`ifdef JK_CNT_SYNC_CLR_EN
      clr_v = ($urandom_range(0, 15) == 0);
`endif
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
